// File: rtl/single_cycle_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | single_cycle_pkg: opcodes, ALU operations and memory reset image   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package single_cycle_pkg;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam logic [4:0]  XZR      = 5'd31;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_ORR   = 3'd3,
    ALU_PASSB = 3'd4
  } alu_op_e;

  function automatic logic [63:0] dmem_reset_val(input int idx);
    case (idx)
      0:       dmem_reset_val = 64'h1;
      1:       dmem_reset_val = 64'hA;
      2:       dmem_reset_val = 64'h5;
      3:       dmem_reset_val = 64'h0FFB_EA7D_EADB_EEFF;
      default: dmem_reset_val = 64'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/single_cycle_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | single_cycle_decode: combinational LEGv8 control decoder           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module single_cycle_decode
  import single_cycle_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rn,
  output logic [4:0]  rm,
  output logic [4:0]  rt,
  output logic        reg2loc,
  output logic        alusrc,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        memwrite,
  output logic        memread,
  output logic        branch,
  output logic        uncondbranch,
  output alu_op_e     aluop,
  output logic [63:0] imm
);

  // op2 field of the D-format is architecturally ignored
  logic unused_op2;
  assign unused_op2 = ^instr[11:10];

  always_comb begin
    rn           = instr[9:5];
    rm           = instr[20:16];
    rt           = instr[4:0];
    reg2loc      = 1'b0;
    alusrc       = 1'b0;
    memtoreg     = 1'b0;
    regwrite     = 1'b0;
    memwrite     = 1'b0;
    memread      = 1'b0;
    branch       = 1'b0;
    uncondbranch = 1'b0;
    aluop        = ALU_ADD;
    imm          = '0;

    if (instr[31:26] == OPC_B) begin
      uncondbranch = 1'b1;
      imm          = {{38{instr[25]}}, instr[25:0]};
    end else if (instr[31:24] == OPC_CBZ) begin
      // Rt passes through the ALU so the zero test reuses its result
      branch  = 1'b1;
      reg2loc = 1'b1;
      aluop   = ALU_PASSB;
      imm     = {{45{instr[23]}}, instr[23:5]};
    end else begin
      case (instr[31:21])
        OPC_LDUR: begin
          alusrc   = 1'b1;
          memtoreg = 1'b1;
          regwrite = 1'b1;
          memread  = 1'b1;
          imm      = {{55{instr[20]}}, instr[20:12]};
        end
        OPC_STUR: begin
          reg2loc  = 1'b1;
          alusrc   = 1'b1;
          memwrite = 1'b1;
          imm      = {{55{instr[20]}}, instr[20:12]};
        end
        OPC_ADD: begin
          regwrite = 1'b1;
          aluop    = ALU_ADD;
        end
        OPC_SUB: begin
          regwrite = 1'b1;
          aluop    = ALU_SUB;
        end
        OPC_AND: begin
          regwrite = 1'b1;
          aluop    = ALU_AND;
        end
        OPC_ORR: begin
          regwrite = 1'b1;
          aluop    = ALU_ORR;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/single_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | single_cycle: single-cycle 64-bit LEGv8 core with ROM and RAM      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module single_cycle
  import single_cycle_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 32
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  output logic [63:0] currentpc,
  output logic [63:0] dmemout
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);
  localparam logic [31:0] INSTR_HALT = 32'h1400_0000;

  logic [63:0] pc_q, pc_d;
  logic [63:0] regs_q [0:31];
  logic [63:0] regs_d [0:31];
  logic [63:0] dmem_q [0:DMEM_WORDS-1];
  logic [63:0] dmem_d [0:DMEM_WORDS-1];
  logic [63:0] dmemout_q, dmemout_d;

  logic [IA_W-1:0] imem_idx;
  logic [DA_W-1:0] dmem_idx;
  logic [31:0]     instr;
  logic [4:0]      rn, rm, rt, rreg2;
  logic            reg2loc, alusrc, memtoreg, regwrite;
  logic            memwrite, memread, branch, uncondbranch;
  alu_op_e         aluop;
  logic [63:0]     imm, rd1, rd2, alu_b, alu_result, dmem_rdata;

  assign imem_idx = pc_q[IA_W+1:2];

  always_comb begin
    case (imem_idx)
      IA_W'(0):  instr = 32'hF840_03E9;  // LDUR X9,[XZR,#0]
      IA_W'(1):  instr = 32'hF840_83EA;  // LDUR X10,[XZR,#8]
      IA_W'(2):  instr = 32'hF841_03EB;  // LDUR X11,[XZR,#16]
      IA_W'(3):  instr = 32'hF841_83EC;  // LDUR X12,[XZR,#24]
      IA_W'(4):  instr = 32'hF842_03ED;  // LDUR X13,[XZR,#32]
      IA_W'(5):  instr = 32'hAA0B_014A;  // ORR X10,X10,X11
      IA_W'(6):  instr = 32'h8A0D_018C;  // AND X12,X12,X13
      IA_W'(7):  instr = 32'hB400_004C;  // CBZ X12,#2
      IA_W'(8):  instr = 32'h8B09_014A;  // ADD X10,X10,X9
      IA_W'(9):  instr = 32'hCB09_014B;  // SUB X11,X10,X9
      IA_W'(10): instr = 32'hF802_83EA;  // STUR X10,[XZR,#40]
      IA_W'(11): instr = 32'h1400_0002;  // B #2
      IA_W'(12): instr = 32'hF802_83EB;  // STUR X11,[XZR,#40]
      IA_W'(13): instr = 32'hF842_83EE;  // LDUR X14,[XZR,#40]
      default:   instr = INSTR_HALT;
    endcase
  end

  single_cycle_decode u_decode (
    .instr        (instr),
    .rn           (rn),
    .rm           (rm),
    .rt           (rt),
    .reg2loc      (reg2loc),
    .alusrc       (alusrc),
    .memtoreg     (memtoreg),
    .regwrite     (regwrite),
    .memwrite     (memwrite),
    .memread      (memread),
    .branch       (branch),
    .uncondbranch (uncondbranch),
    .aluop        (aluop),
    .imm          (imm)
  );

  always_comb begin
    rreg2 = reg2loc ? rt : rm;
    rd1   = (rn == XZR)    ? 64'd0 : regs_q[rn];
    rd2   = (rreg2 == XZR) ? 64'd0 : regs_q[rreg2];
    alu_b = alusrc ? imm : rd2;
    case (aluop)
      ALU_ADD:   alu_result = rd1 + alu_b;
      ALU_SUB:   alu_result = rd1 - alu_b;
      ALU_AND:   alu_result = rd1 & alu_b;
      ALU_ORR:   alu_result = rd1 | alu_b;
      default:   alu_result = alu_b;
    endcase
  end

  assign dmem_idx   = alu_result[DA_W+2:3];
  assign dmem_rdata = dmem_q[dmem_idx];

  always_comb begin
    pc_d = pc_q + 64'd4;
    if (uncondbranch || (branch && (alu_result == 64'd0))) begin
      pc_d = pc_q + (imm << 2);
    end

    regs_d = regs_q;
    if (regwrite && (rt != XZR)) begin
      regs_d[rt] = memtoreg ? dmem_rdata : alu_result;
    end

    dmem_d = dmem_q;
    if (memwrite) begin
      dmem_d[dmem_idx] = rd2;
    end

    dmemout_d = dmemout_q;
    if (memread) begin
      dmemout_d = dmem_rdata;
    end
  end

  always_ff @(posedge CLK or posedge resetl) begin
    if (resetl) begin
      pc_q      <= startpc;
      dmemout_q <= '0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      for (int i = 0; i < DMEM_WORDS; i++) begin
        dmem_q[i] <= dmem_reset_val(i);
      end
    end else begin
      pc_q      <= pc_d;
      dmemout_q <= dmemout_d;
      regs_q    <= regs_d;
      dmem_q    <= dmem_d;
    end
  end

  assign currentpc = pc_q;
  assign dmemout   = dmemout_q;

endmodule
`default_nettype wire

// File: tb/tb_single_cycle.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_single_cycle: directed and randomized checks against an ISA model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_single_cycle;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [63:0] startpc;
  logic [63:0] currentpc;
  logic [63:0] dmemout;

  single_cycle #(.IMEM_WORDS(64), .DMEM_WORDS(32)) dut (
    .CLK       (CLK),
    .resetl    (resetl),
    .startpc   (startpc),
    .currentpc (currentpc),
    .dmemout   (dmemout)
  );

  always #5 CLK = ~CLK;

  int passes = 0;
  int checks = 0;

  // Assembly-level program listing interpreted by the reference model
  localparam int K_LDUR = 0, K_STUR = 1, K_ADD = 2, K_SUB = 3;
  localparam int K_AND = 4, K_ORR = 5, K_CBZ = 6, K_B = 7;

  int          p_kind [64];
  int          p_t    [64];
  int          p_n    [64];
  int          p_m    [64];
  longint      p_imm  [64];
  logic [63:0] m_x    [32];
  logic [63:0] m_mem  [32];
  logic [63:0] m_pc;
  logic [63:0] m_dout;

  task automatic put(input int addr, input int kind, input int t, input int n,
                     input int m, input longint imm);
    p_kind[addr/4] = kind; p_t[addr/4] = t; p_n[addr/4] = n;
    p_m[addr/4] = m; p_imm[addr/4] = imm;
  endtask

  task automatic load_program();
    for (int i = 0; i < 64; i++) begin
      p_kind[i] = K_B; p_t[i] = 0; p_n[i] = 0; p_m[i] = 0; p_imm[i] = 0;
    end
    put('h00, K_LDUR,  9, 31,  0,  0);
    put('h04, K_LDUR, 10, 31,  0,  8);
    put('h08, K_LDUR, 11, 31,  0, 16);
    put('h0C, K_LDUR, 12, 31,  0, 24);
    put('h10, K_LDUR, 13, 31,  0, 32);
    put('h14, K_ORR,  10, 10, 11,  0);
    put('h18, K_AND,  12, 12, 13,  0);
    put('h1C, K_CBZ,  12,  0,  0,  2);
    put('h20, K_ADD,  10, 10,  9,  0);
    put('h24, K_SUB,  11, 10,  9,  0);
    put('h28, K_STUR, 10, 31,  0, 40);
    put('h2C, K_B,     0,  0,  0,  2);
    put('h30, K_STUR, 11, 31,  0, 40);
    put('h34, K_LDUR, 14, 31,  0, 40);
  endtask

  function automatic logic [63:0] rx(input int r);
    return (r == 31) ? 64'd0 : m_x[r];
  endfunction

  task automatic wx(input int r, input logic [63:0] v);
    if (r != 31) m_x[r] = v;
  endtask

  task automatic model_reset(input logic [63:0] spc);
    m_pc = spc;
    m_dout = 64'd0;
    for (int i = 0; i < 32; i++) begin
      m_x[i] = 64'd0;
      m_mem[i] = 64'd0;
    end
    m_mem[0] = 64'h1;
    m_mem[1] = 64'hA;
    m_mem[2] = 64'h5;
    m_mem[3] = 64'h0FFB_EA7D_EADB_EEFF;
  endtask

  task automatic model_step();
    int          w;
    logic [63:0] a;
    logic [63:0] nxt;
    w   = int'((m_pc >> 2) % 64);
    nxt = m_pc + 64'd4;
    case (p_kind[w])
      K_LDUR: begin
        a = rx(p_n[w]) + 64'(p_imm[w]);
        m_dout = m_mem[int'((a >> 3) % 32)];
        wx(p_t[w], m_dout);
      end
      K_STUR: begin
        a = rx(p_n[w]) + 64'(p_imm[w]);
        m_mem[int'((a >> 3) % 32)] = rx(p_t[w]);
      end
      K_ADD: wx(p_t[w], rx(p_n[w]) + rx(p_m[w]));
      K_SUB: wx(p_t[w], rx(p_n[w]) - rx(p_m[w]));
      K_AND: wx(p_t[w], rx(p_n[w]) & rx(p_m[w]));
      K_ORR: wx(p_t[w], rx(p_n[w]) | rx(p_m[w]));
      K_CBZ: if (rx(p_t[w]) == 64'd0) nxt = m_pc + 64'(p_imm[w] * 4);
      default: nxt = m_pc + 64'(p_imm[w] * 4);
    endcase
    m_pc = nxt;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  // Reset assertion is immediate; release follows the next rising edge
  task automatic do_reset(input logic [63:0] spc);
    startpc = spc;
    resetl  = 1'b1;
    model_reset(spc);
    #1;
    check("rst_pc", currentpc, spc);
    check("rst_dmemout", dmemout, 64'd0);
    @(posedge CLK);
    #1;
    resetl = 1'b0;
  endtask

  task automatic run_compare(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("model_pc", currentpc, m_pc);
      check("model_dmemout", dmemout, m_dout);
    end
  endtask

  task automatic program1_results();
    check("x10", dut.regs_q[10], 64'hF);
    check("x11", dut.regs_q[11], 64'hE);
    check("x12", dut.regs_q[12], 64'h0);
    check("x14", dut.regs_q[14], 64'hF);
    check("mem28", dut.dmem_q[5], 64'hF);
    check("xzr", dut.regs_q[31], 64'h0);
  endtask

  logic [63:0] exp_pcs [14];
  int          bad_seen;
  int          guard;
  logic [63:0] spc;
  logic [63:0] hi;

  initial begin
    resetl  = 1'b1;
    startpc = 64'd0;
    load_program();
    exp_pcs = '{64'h00, 64'h04, 64'h08, 64'h0C, 64'h10, 64'h14, 64'h18,
                64'h1C, 64'h24, 64'h28, 64'h2C, 64'h34, 64'h38, 64'h38};

    // Program 1 from startpc 0
    do_reset(64'd0);
    bad_seen = 0;
    for (int i = 0; i < 13; i++) begin
      check("pc_seq", currentpc, exp_pcs[i]);
      check("seq_dmemout", dmemout, m_dout);
      if (currentpc == 64'h20 || currentpc == 64'h30) bad_seen++;
      if (i < 12) step();
    end
    check("skipped_pcs_seen", 64'(bad_seen), 64'd0);
    check("dmemout_after_0x34", dmemout, 64'hF);
    check("xzr_base_load_x9", dut.regs_q[9], 64'h1);
    program1_results();

    // Halt loop
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_pc", currentpc, 64'h38);
      check("halt_dmemout", dmemout, 64'hF);
    end

    // Asynchronous reset from the halt state, then again at PC 0x18
    #3;
    do_reset(64'd0);
    guard = 0;
    while (currentpc !== 64'h18 && guard < 20) begin
      step();
      guard++;
    end
    check("reach_0x18", currentpc, 64'h18);
    #2;
    do_reset(64'd0);
    run_compare(12);
    check("rerun_pc", currentpc, 64'h38);
    check("rerun_dmemout", dmemout, 64'hF);
    program1_results();

    // Nonzero start address
    do_reset(64'h34);
    step();
    check("start34_dmemout", dmemout, 64'd0);
    check("start34_pc", currentpc, 64'h38);

    // Random start points, run lengths and asynchronous reset timing
    for (int t = 0; t < 8; t++) begin
      hi  = {$urandom, $urandom};
      spc = (t % 3 == 0) ? {hi[63:8], 8'(4 * $urandom_range(15, 0))}
                         : 64'(4 * $urandom_range(15, 0));
      #($urandom_range(7, 1));
      do_reset(spc);
      run_compare(int'($urandom_range(20, 3)));
      for (int r = 9; r <= 14; r++) check("model_reg", dut.regs_q[r], m_x[r]);
      check("model_mem28", dut.dmem_q[5], m_mem[5]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/single_cycle.md
Name: single_cycle

Overview:
- Single-cycle 64-bit ARMv8 (LEGv8 subset) processor core.
- Contains the PC, instruction ROM, register file, ALU and data memory.
- Executes one instruction per rising clock edge.
- Top-level CPU block: exposes the current PC and the last loaded data word for system-level checking.

Parameters:
- IMEM_WORDS, 64, number of 32-bit instruction ROM words; indexed by PC[7:2].
- DMEM_WORDS, 32, number of 64-bit data memory words; indexed by address[7:3].

Ports:
- CLK  input  1  rising-edge clock.
- resetl  input  1  reset; asynchronous, active-high (asserted when 1).
- startpc  input  64  PC value loaded while reset is asserted.
- currentpc  output  64  address of the instruction currently executing.
- dmemout  output  64  registered data returned by the most recent LDUR.

Behaviour:
- Reset (resetl=1, async):
  - PC=startpc; X0-X30=0; dmemout=0.
  - Data memory reinitialised to: [0x00]=1, [0x08]=0xA, [0x10]=5, [0x18]=0x0FFBEA7DEADBEEFF, [0x20]=0, all other words 0.
- Each rising edge with resetl=0 commits exactly one instruction:
  - PC update.
  - Optional register write.
  - Optional memory write.
  - On LDUR only, dmemout is updated with the loaded word.
- currentpc=PC combinationally.
- Instructions are 32-bit. Opcodes are decoded from the top bits:
  - LDUR 11111000010: Rt = M[Rn + sext(imm9 [20:12])]
  - STUR 11111000000: M[Rn + sext(imm9)] = Rt
  - ADD 10001011000: Rd = Rn + Rm
  - SUB 11001011000: Rd = Rn - Rm
  - AND 10001010000: Rd = Rn & Rm
  - ORR 10101010000: Rd = Rn | Rm
  - CBZ 10110100: if Rt==0, PC = PC + sext(imm19 [23:5])<<2, else PC+4
  - B 000101: PC = PC + sext(imm26)<<2
- Any other encoding is a NOP: PC+4, no writes.
- X31 (XZR) always reads 0; writes to it are discarded.
- Register file: two combinational read ports, one write port on the clock edge.
- All arithmetic is modulo 2^64; PC wraps modulo 2^64.
- Memory addressing:
  - Data address low 3 bits are ignored; out-of-range addresses wrap via the index bits.
  - Instruction fetch beyond IMEM_WORDS wraps via the index bits.
  - Data memory reads are combinational; writes occur on the clock edge.
- Instruction ROM contents, fixed (all unlisted words are B #0):
  - 0x00 LDUR X9,[XZR,#0]
  - 0x04 LDUR X10,[XZR,#8]
  - 0x08 LDUR X11,[XZR,#16]
  - 0x0C LDUR X12,[XZR,#24]
  - 0x10 LDUR X13,[XZR,#32]
  - 0x14 ORR X10,X10,X11
  - 0x18 AND X12,X12,X13
  - 0x1C CBZ X12,#2
  - 0x20 ADD X10,X10,X9
  - 0x24 SUB X11,X10,X9
  - 0x28 STUR X10,[XZR,#40]
  - 0x2C B #2
  - 0x30 STUR X11,[XZR,#40]
  - 0x34 LDUR X14,[XZR,#40]
  - 0x38 B #0 (halt loop)
- Reset asserted mid-program immediately restores the full reset state; execution restarts at startpc after release.

Decomposition:
- Shared package single_cycle_pkg:
  - opcode constants (LDUR, STUR, ADD, SUB, AND, ORR, CBZ, B);
  - ALU-operation enum (ADD, SUB, AND, ORR, PASSB);
  - XZR index constant 31.
- One sub-module, single_cycle_decode: combinational control decoder.
  - Input: instruction.
  - Outputs: reg2loc, alusrc, memtoreg, regwrite, memwrite, memread, branch, uncondbranch, aluop, sign-extended immediate.
- Register file, ALU and memories stay inline in the top.

Test Plan:
- Program 1: startpc=0, hold reset 1 cycle, release.
  - PC sequence 0x00..0x1C, then 0x24, 0x28, 0x2C, 0x34, 0x38.
  - Edge committing 0x34 sets dmemout=0xF.
- Branches: 0x20 and 0x30 are never observed on currentpc.
  - After the run, X10=0xF, X11=0xE, X12=0, M[0x28]=0xF.
- Halt: after reaching 0x38, 10 further cycles.
  - currentpc stays 0x38; dmemout stays 0xF.
- Reset mid-run: assert resetl asynchronously while PC=0x18.
  - currentpc=startpc and dmemout=0 immediately, without waiting for a clock edge.
  - Rerun reproduces Program 1 results.
- Nonzero startpc=0x34 from reset: first edge loads M[0x28], which is 0 after reset.
  - dmemout=0; PC=0x38.
- XZR: with reset state, verify any read of register 31 yields 0.
  - Writeback targeting 31 leaves it 0.
